joystick_scan: RTL

Parametrised multi-port joystick front end: synchronises and debounces NUM_JOY raw active-low joystick ports of BTN_W switches each, presents debounced active-high state continuously, and reports every debounced change as an event through a valid/ready handshake with round-robin arbitration across ports. It sits between the board joystick pins and the core logic, in the 50 MHz domain.

---
 rtl/joystick_scan.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/joystick_scan.sv
// Multi-port joystick front end: sync, debounce, round-robin change events.
// Optional autofire on the fire bit when JOY_AUTOFIRE_EN is defined.
module joystick_scan #(
  parameter int NUM_JOY    = 2,
  parameter int BTN_W      = 5,
  parameter int DEB_CYCLES = 250000,
  parameter int CNT_W      = 18,
`ifdef JOY_AUTOFIRE_EN
  parameter int AF_HALF    = 2500000,
`endif
  localparam int CHAN_W    = (NUM_JOY > 1) ? $clog2(NUM_JOY) : 1
) (
  input  logic                     i_clk50,
  input  logic                     i_rst_n,
  input  logic [NUM_JOY*BTN_W-1:0] i_joy,
  output logic [NUM_JOY*BTN_W-1:0] o_joy,
  output logic                     o_evt_valid,
  input  logic                     i_evt_ready,
  output logic [CHAN_W-1:0]        o_evt_chan,
  output logic [BTN_W-1:0]         o_evt_state,
  output logic                     o_evt_ovf
`ifdef JOY_AUTOFIRE_EN
  ,
  input  logic [NUM_JOY-1:0]       i_af_en
`endif
);

  localparam int FIRE_BIT = 4;
`ifdef JOY_AUTOFIRE_EN
  localparam int AF_W = $clog2(AF_HALF + 1);
`endif

  logic [NUM_JOY-1:0]       pending_vec;
  logic [NUM_JOY-1:0]       ovf_vec;
  logic [NUM_JOY*BTN_W-1:0] stable_all;

  logic                     grant_found;
  logic [CHAN_W-1:0]        grant_idx;
  logic                     load;
  logic [BTN_W-1:0]         sel_state;
  logic                     sel_ovf;

  logic                     evt_valid_reg;
  logic [CHAN_W-1:0]        evt_chan_reg;
  logic [BTN_W-1:0]         evt_state_reg;
  logic                     evt_ovf_reg;
  logic [CHAN_W-1:0]        last_grant_reg;

  assign load = grant_found && (!evt_valid_reg || i_evt_ready);

  for (genvar gi = 0; gi < NUM_JOY; gi++) begin : g_port
    logic [BTN_W-1:0] sync1_reg;
    logic [BTN_W-1:0] sync2_reg;
    logic [BTN_W-1:0] synced_prev_reg;
    logic [BTN_W-1:0] stable_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             pending_reg;
    logic             ovf_reg;
    logic [BTN_W-1:0] synced;
    logic             differs;
    logic             restart;
    logic             deb_done;
    logic             grant;

    assign synced   = ~sync2_reg;
    assign differs  = (synced != stable_reg);
    // A change while already counting means the input is still bouncing.
    assign restart  = (cnt_reg != '0) && (synced != synced_prev_reg);
    assign deb_done = differs && !restart && (cnt_reg == CNT_W'(DEB_CYCLES - 1));
    assign grant    = load && (grant_idx == CHAN_W'(gi));

    always_ff @(posedge i_clk50) begin
      if (!i_rst_n) begin
        sync1_reg       <= '1;
        sync2_reg       <= '1;
        synced_prev_reg <= '0;
        stable_reg      <= '0;
        cnt_reg         <= '0;
        pending_reg     <= 1'b0;
        ovf_reg         <= 1'b0;
      end else begin
        sync1_reg       <= i_joy[gi*BTN_W +: BTN_W];
        sync2_reg       <= sync1_reg;
        synced_prev_reg <= synced;

        if (!differs || restart) begin
          cnt_reg <= '0;
        end else if (deb_done) begin
          cnt_reg    <= '0;
          stable_reg <= synced;
        end else begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end

        // A completion coinciding with the load re-arms pending for the new state.
        if (grant) begin
          pending_reg <= deb_done;
          ovf_reg     <= 1'b0;
        end else if (deb_done) begin
          pending_reg <= 1'b1;
          ovf_reg     <= ovf_reg | pending_reg;
        end
      end
    end

    assign pending_vec[gi]                = pending_reg;
    assign ovf_vec[gi]                    = ovf_reg;
    assign stable_all[gi*BTN_W +: BTN_W]  = stable_reg;

`ifdef JOY_AUTOFIRE_EN
    logic [AF_W-1:0]  af_cnt_reg;
    logic             af_phase_reg;
    logic [BTN_W-1:0] joy_out;

    always_ff @(posedge i_clk50) begin
      if (!i_rst_n || !stable_reg[FIRE_BIT]) begin
        af_cnt_reg   <= '0;
        af_phase_reg <= 1'b1;
      end else if (af_cnt_reg == AF_W'(AF_HALF - 1)) begin
        af_cnt_reg   <= '0;
        af_phase_reg <= ~af_phase_reg;
      end else begin
        af_cnt_reg <= af_cnt_reg + AF_W'(1);
      end
    end

    always_comb begin
      joy_out           = stable_reg;
      joy_out[FIRE_BIT] = stable_reg[FIRE_BIT] & (af_phase_reg | ~i_af_en[gi]);
    end

    assign o_joy[gi*BTN_W +: BTN_W] = joy_out;
`else
    assign o_joy[gi*BTN_W +: BTN_W] = stable_reg;
`endif
  end

  // Round-robin: ports above the last grant first, then wrap to port 0.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int j = 0; j < NUM_JOY; j++) begin
      if (!grant_found && pending_vec[j] && (j > int'(last_grant_reg))) begin
        grant_found = 1'b1;
        grant_idx   = CHAN_W'(j);
      end
    end
    for (int j = 0; j < NUM_JOY; j++) begin
      if (!grant_found && pending_vec[j] && (j <= int'(last_grant_reg))) begin
        grant_found = 1'b1;
        grant_idx   = CHAN_W'(j);
      end
    end
  end

  always_comb begin
    sel_state = '0;
    sel_ovf   = 1'b0;
    for (int j = 0; j < NUM_JOY; j++) begin
      if (CHAN_W'(j) == grant_idx) begin
        sel_state = stable_all[j*BTN_W +: BTN_W];
        sel_ovf   = ovf_vec[j];
      end
    end
  end

  always_ff @(posedge i_clk50) begin
    if (!i_rst_n) begin
      evt_valid_reg  <= 1'b0;
      evt_chan_reg   <= '0;
      evt_state_reg  <= '0;
      evt_ovf_reg    <= 1'b0;
      last_grant_reg <= CHAN_W'(NUM_JOY - 1);
    end else if (load) begin
      evt_valid_reg  <= 1'b1;
      evt_chan_reg   <= grant_idx;
      evt_state_reg  <= sel_state;
      evt_ovf_reg    <= sel_ovf;
      last_grant_reg <= grant_idx;
    end else if (i_evt_ready) begin
      evt_valid_reg <= 1'b0;
    end
  end

  assign o_evt_valid = evt_valid_reg;
  assign o_evt_chan  = evt_chan_reg;
  assign o_evt_state = evt_state_reg;
  assign o_evt_ovf   = evt_ovf_reg;

endmodule
